ram_sync_clr: RTL and testbench
===============================

RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits; legal range 1..64.
REQ-002 Parameter AW, default 6: address width in bits; depth DEPTH = 2**AW words; legal range 1..12.
REQ-003 Port CLK  input  1: single clock; all state changes on the rising edge.
REQ-004 Port RST  input  1: reset; synchronous, active-high.
REQ-005 Port E  input  1: chip enable; when 0, W and R are ignored.
REQ-006 Port W  input  1: write request, qualified by E.
REQ-007 Port R  input  1: read request, qualified by E.
REQ-008 Port ADDR  input  AW: word address for both read and write.
REQ-009 Port D  input  WIDTH: write data.
REQ-010 Port OUT  output  WIDTH: registered read data.
REQ-011 Port VALID  output  1: OUT carries fresh read data this cycle.
REQ-012 Port BUSY  output  1: clear sequence in progress; requests are ignored.

Function
REQ-013 FSM states: CLEAR and IDLE; CLEAR is entered from reset, and IDLE is entered from CLEAR after the last address is written.
REQ-014 In CLEAR, one word per cycle is written to 0, with the clear pointer running 0..DEPTH-1; the exit to IDLE happens on the edge that writes address DEPTH-1; clear duration is exactly DEPTH cycles.
REQ-015 BUSY=1 throughout CLEAR and 0 in IDLE.
REQ-016 In CLEAR, E/W/R/ADDR/D are ignored: no user write, and VALID stays 0.
REQ-017 Write in IDLE: when E&W are sampled high at an edge, mem[ADDR] is set to D at that edge.
REQ-018 Read in IDLE: when E&R are sampled high at edge N, OUT = mem[ADDR] and VALID=1 after edge N. Latency is 1 cycle.
REQ-019 VALID drops to 0 on the first edge where no read is accepted; VALID is a single-cycle pulse per accepted read.
REQ-020 OUT holds the last read value when no read is accepted; it never goes X or 0 between reads.
REQ-021 Simultaneous E&W&R to the same address is read-first: OUT receives the old contents, and the new data is visible to the next read.
REQ-022 Simultaneous E&W&R to different addresses performs both operations in the same cycle.
REQ-023 All ADDR values 0..DEPTH-1 are valid; there is no out-of-range case and no wrap logic beyond the AW-bit pointer.
REQ-024 Back-to-back reads are accepted every cycle, giving VALID continuously high and OUT updating each cycle.

Reset
REQ-025 Whenever RST=1 at an edge: state is CLEAR, the clear pointer is 0, OUT=0, VALID=0, and BUSY=1 from the following cycle.
REQ-026 A reset asserted mid-clear or mid-read restarts the clear from address 0; an in-flight read is discarded, and VALID=0.
REQ-027 RST has priority over E, W and R in the same cycle.

Configuration
REQ-028 Macro RAM_SYNC_CLR_CLEAR_ON_RESET_EN enables the clear-on-reset feature.
REQ-029 With RAM_SYNC_CLR_CLEAR_ON_RESET_EN defined, the CLEAR state and clear pointer exist and behave per REQ-013..REQ-016.
REQ-030 Without RAM_SYNC_CLR_CLEAR_ON_RESET_EN:
- reset goes directly to IDLE;
- memory contents are preserved across reset;
- BUSY is tied to 0;
- OUT and VALID still reset to 0.

Verification
REQ-031 Defaults, clear with macro on: pulse RST for 1 cycle. BUSY must be 1 for exactly 64 cycles, then read all 64 addresses; every OUT must be 0x0000, with VALID=1 one cycle after each request.
REQ-032 Write/read: write 0xA5A5 to address 5 and 0x1234 to address 63, then read 5 and 63 back-to-back. Required response: OUT=0xA5A5 then 0x1234 on consecutive cycles, with VALID high for 2 cycles.
REQ-033 Read-during-write: with address 7 holding 0x0001, E=W=R=1, ADDR=7, D=0x00FF. Required response: OUT=0x0001 that cycle; the next read of address 7 gives 0x00FF.
REQ-034 Ignore during busy: with E=W=1, ADDR=3, D=0xFFFF held throughout CLEAR, the read of address 3 after BUSY falls must return 0x0000.
REQ-035 Reset mid-operation: assert RST at clear pointer 20. BUSY must stay 1 for 64 further cycles after RST deasserts. Separately, RST during a read cycle must give VALID=0 and OUT=0 on the next cycle.
REQ-036 Macro off, WIDTH=8, AW=3: write 0x3C to address 2, pulse RST, then read address 2. Required response: OUT=0x3C with VALID=1, and BUSY is never 1.

Source files
------------

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with registered read data and a read-first write/read collision.
// Define RAM_SYNC_CLR_CLEAR_ON_RESET_EN to zero every word, one per cycle, after each reset.
module ram_sync_clr #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             E,
  input  logic             W,
  input  logic             R,
  input  logic [AW-1:0]    ADDR,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID,
  output logic             BUSY
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out;
  logic             r_valid;

  logic             w_idle;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_ptr;
  logic             w_user_we;
  logic             w_rd;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_addr;
  logic [WIDTH-1:0] w_mem_data;

`ifdef RAM_SYNC_CLR_CLEAR_ON_RESET_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_clr_ptr;
  logic          r_busy;

  // Clear sequencer: leaves CLEAR on the edge that zeroes the last word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_clr_ptr <= r_clr_ptr + AW'(1);
      if (r_clr_ptr == AW'(DEPTH - 1)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end

  assign w_idle    = (r_state == S_IDLE);
  assign w_clr_we  = (r_state == S_CLEAR) && !RST;
  assign w_clr_ptr = r_clr_ptr;
  assign BUSY      = r_busy;
`else
  assign w_idle    = 1'b1;
  assign w_clr_we  = 1'b0;
  assign w_clr_ptr = '0;
  assign BUSY      = 1'b0;
`endif

  assign w_user_we = w_idle && E && W && !RST;
  assign w_rd      = w_idle && E && R && !RST;

  // Clear writes and user writes are mutually exclusive by state.
  always_comb begin
    w_mem_we   = w_clr_we || w_user_we;
    w_mem_addr = ADDR;
    w_mem_data = D;
    if (w_clr_we) begin
      w_mem_addr = w_clr_ptr;
      w_mem_data = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Read port samples the pre-write contents, giving read-first on collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_rd;
      if (w_rd) begin
        r_out <= r_mem[ADDR];
      end
    end
  end

  assign OUT   = r_out;
  assign VALID = r_valid;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed self-checking bench for ram_sync_clr; adapts expectations to the clear-on-reset build option.
module tb_ram_sync_clr;

`ifdef RAM_SYNC_CLR_CLEAR_ON_RESET_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, e, w, r;
  logic [5:0]  addr;
  logic [15:0] d;
  logic [15:0] out;
  logic        valid, busy;

  logic        s_rst, s_e, s_w, s_r;
  logic [2:0]  s_addr;
  logic [7:0]  s_d;
  logic [7:0]  s_out;
  logic        s_valid, s_busy;

  int checks = 0;
  int errors = 0;
  int cnt;
  bit valid_in_busy = 1'b0;
  bit s_busy_seen   = 1'b0;

  ram_sync_clr #(.WIDTH(16), .AW(6)) u_dut (
    .CLK(clk), .RST(rst), .E(e), .W(w), .R(r), .ADDR(addr), .D(d),
    .OUT(out), .VALID(valid), .BUSY(busy)
  );

  ram_sync_clr #(.WIDTH(8), .AW(3)) u_small (
    .CLK(clk), .RST(s_rst), .E(s_e), .W(s_w), .R(s_r), .ADDR(s_addr), .D(s_d),
    .OUT(s_out), .VALID(s_valid), .BUSY(s_busy)
  );

  always @(posedge clk) if (s_busy === 1'b1 && s_rst === 1'b0) s_busy_seen <= 1'b1;

  typedef struct {
    logic        rst, e, w, r;
    logic [5:0]  addr;
    logic [15:0] d;
    logic        exp_valid;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with BUSY high, starting from the current sample; bounded.
  task automatic count_busy(input bit sm, output int n);
    n = 0;
    if ((sm ? s_busy : busy) === 1'b1) n = 1;
    for (int i = 0; i < 200; i++) begin
      if (n == 0) break;
      step();
      if (!sm && valid !== 1'b0) valid_in_busy = 1'b1;
      if ((sm ? s_busy : busy) === 1'b1) n++;
      else break;
    end
  endtask

  initial begin
    rst = 1'b1; e = 1'b0; w = 1'b0; r = 1'b0; addr = '0; d = '0;
    s_rst = 1'b1; s_e = 1'b0; s_w = 1'b0; s_r = 1'b0; s_addr = '0; s_d = '0;

    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd5,  16'hA5A5, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd63, 16'h1234, 1'b0, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  16'h0000, 1'b1, 16'hA5A5};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 16'h0000, 1'b1, 16'h1234};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b0, 16'h1234};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd7,  16'h0001, 1'b0, 16'h1234};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd7,  16'h00FF, 1'b1, 16'h0001};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd7,  16'h0000, 1'b1, 16'h00FF};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd7,  16'hBEEF, 1'b0, 16'h00FF};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd7,  16'h0000, 1'b1, 16'h00FF};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd10, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd0,  16'h0042, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd0,  16'h0000, 1'b1, 16'h0042};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd5,  16'h0000, 1'b1, 16'hA5A5};

    // Reset values
    step();
    chk("rst.OUT", 64'(out), 64'h0);
    chk("rst.VALID", 64'(valid), 64'h0);
    chk("rst.BUSY", 64'(busy), 64'(CLR_EN));
    rst = 1'b0; s_rst = 1'b0;

    if (CLR_EN) begin
      // Requests held during the clear must be ignored
      e = 1'b1; w = 1'b1; r = 1'b1; addr = 6'd3; d = 16'hFFFF;
      count_busy(1'b0, cnt);
      e = 1'b0; w = 1'b0; r = 1'b0;
      chk("clear.cycles", 64'(cnt), 64'd64);
      chk("clear.valid_low", 64'(valid_in_busy), 64'h0);
    end else begin
      for (int i = 0; i < 64; i++) begin
        e = 1'b1; w = 1'b1; addr = 6'(i); d = 16'h0000;
        step();
      end
      e = 1'b0; w = 1'b0;
    end

    for (int i = 0; i < 64; i++) begin
      e = 1'b1; r = 1'b1; addr = 6'(i);
      step();
      chk($sformatf("zero[%0d].VALID", i), 64'(valid), 64'h1);
      chk($sformatf("zero[%0d].OUT", i), 64'(out), 64'h0);
    end
    e = 1'b0; r = 1'b0;
    step();
    chk("post_read.VALID", 64'(valid), 64'h0);

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; e = vecs[i].e; w = vecs[i].w; r = vecs[i].r;
      addr = vecs[i].addr; d = vecs[i].d;
      step();
      chk($sformatf("vec[%0d].VALID", i), 64'(valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec[%0d].OUT", i), 64'(out), 64'(vecs[i].exp_out));
    end

    // Reset during a read discards it
    rst = 1'b1; e = 1'b1; r = 1'b1; w = 1'b0; addr = 6'd5;
    step();
    rst = 1'b0; e = 1'b0; r = 1'b0;
    chk("rst_rd.VALID", 64'(valid), 64'h0);
    chk("rst_rd.OUT", 64'(out), 64'h0);
    chk("rst_rd.BUSY", 64'(busy), 64'(CLR_EN));

    if (CLR_EN) begin
      // Reset again once the clear pointer reaches 20
      for (int i = 0; i < 20; i++) step();
      chk("mid.BUSY", 64'(busy), 64'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      count_busy(1'b0, cnt);
      chk("mid.cycles", 64'(cnt), 64'd64);
    end

    e = 1'b1; r = 1'b1; addr = 6'd5;
    step();
    chk("after_rst5.VALID", 64'(valid), 64'h1);
    chk("after_rst5.OUT", 64'(out), CLR_EN ? 64'h0 : 64'hA5A5);
    addr = 6'd0;
    step();
    chk("after_rst0.OUT", 64'(out), CLR_EN ? 64'h0 : 64'h0042);
    e = 1'b0; r = 1'b0;
    chk("after_rst.BUSY", 64'(busy), 64'h0);

    // Small instance: write, reset, read back
    if (CLR_EN) begin
      s_rst = 1'b1; step(); s_rst = 1'b0;
      count_busy(1'b1, cnt);
      chk("small.clear1", 64'(cnt), 64'd8);
    end
    s_e = 1'b1; s_w = 1'b1; s_addr = 3'd2; s_d = 8'h3C;
    step();
    s_e = 1'b0; s_w = 1'b0; s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    chk("small.rst.VALID", 64'(s_valid), 64'h0);
    chk("small.rst.OUT", 64'(s_out), 64'h0);
    if (CLR_EN) begin
      count_busy(1'b1, cnt);
      chk("small.clear2", 64'(cnt), 64'd8);
    end
    s_e = 1'b1; s_r = 1'b1; s_addr = 3'd2;
    step();
    s_e = 1'b0; s_r = 1'b0;
    chk("small.rd.VALID", 64'(s_valid), 64'h1);
    chk("small.rd.OUT", 64'(s_out), CLR_EN ? 64'h0 : 64'h3C);
    step();
    chk("small.rd.pulse", 64'(s_valid), 64'h0);
    if (!CLR_EN) chk("small.busy_never", 64'(s_busy_seen), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
